glitc_ctrl_bus_initiator: RTL

- Bus initiator (master) for the GLITC 4-word control register file on the user bus.
- Runs three fixed transaction sequences on command pulses:
  - fetch the 57-bit device DNA through the serial DNA register;
  - request an input realign, then poll for completion with a timeout;
  - issue a housekeeping-update write.
- Sits between local sequencing/test logic and the control register file, in the user_clk_i domain.

---
 rtl/glitc_ctrl_bus_initiator_pkg.sv | 41 ++++
 rtl/glitc_bus_strobe.sv | 56 +++++
 rtl/glitc_ctrl_bus_initiator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/glitc_ctrl_bus_initiator_pkg.sv
// Shared definitions for the GLITC control-bus initiator: register map,
// CONTROL register bit positions and the sequencer state encoding.
package glitc_ctrl_bus_initiator_pkg;

    // Word addresses of the control register file
    localparam logic [1:0] ADDR_IDENT   = 2'd0;
    localparam logic [1:0] ADDR_VERSION = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_DNA     = 2'd3;

    // CONTROL register fields
    localparam int CTRL_CLK_LSB       = 0;
    localparam int CTRL_CLK_MSB       = 2;
    localparam int CTRL_REALIGN_BIT   = 4;
    localparam int CTRL_REALIGNED_BIT = 5;

    // Writing this bit of the DNA register loads the serial DNA shifter
    localparam int DNA_LOAD_BIT = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DNA_LOAD,
        ST_DNA_GAP,
        ST_DNA_RD,
        ST_RA_WR,
        ST_RA_GAP,
        ST_RA_RD,
        ST_HSK_WR
    } state_t;

    // CONTROL word for a realign request: clock control in [2:0], realign
    // request in bit 4; bit 3 and the top bits (including 31) stay zero.
    function automatic logic [31:0] realign_word(input logic [2:0] clk_control);
        logic [31:0] w;
        w = '0;
        w[CTRL_CLK_MSB:CTRL_CLK_LSB] = clk_control;
        w[CTRL_REALIGN_BIT]          = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/glitc_bus_strobe.sv
// Registered one-cycle bus strobe generator. A request presented in cycle N
// appears on the bus in cycle N+1 for exactly one cycle. The gap counter is
// loaded together with the strobe and runs down through the idle cycles that
// follow it, so gap_done rises after exactly gap_len idle cycles.
module glitc_bus_strobe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_dat,
    input  logic [15:0] gap_len,
    output logic        sel,
    output logic        wr,
    output logic        rd,
    output logic [1:0]  addr,
    output logic [31:0] dat,
    output logic        gap_done
);

    logic        strobe;
    logic [15:0] gap_cnt;

    assign strobe = wr_req | rd_req;

    // Bus output register; address and data are forced to zero between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 1'b0;
            wr   <= 1'b0;
            rd   <= 1'b0;
            addr <= '0;
            dat  <= '0;
        end else begin
            sel  <= strobe;
            wr   <= wr_req;
            rd   <= rd_req & ~wr_req;
            addr <= strobe ? req_addr : 2'd0;
            dat  <= wr_req ? req_dat : 32'd0;
        end
    end

    // Gap counter: reloaded with each strobe, counts down to zero and holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (strobe) begin
            gap_cnt <= gap_len;
        end else if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
        end
    end

    assign gap_done = (gap_cnt == 16'd0);

endmodule

// File: rtl/glitc_ctrl_bus_initiator.sv
// Bus initiator for the GLITC control register file. Runs the DNA fetch,
// realign-with-poll and housekeeping-update sequences on command pulses.
module glitc_ctrl_bus_initiator
    import glitc_ctrl_bus_initiator_pkg::*;
#(
    parameter int GAP_CYCLES    = 3,
    parameter int POLL_INTERVAL = 16,
    parameter int POLL_LIMIT    = 255,
    parameter int DNA_BITS      = 57
) (
    input  logic        user_clk_i,
    input  logic        user_rst_n_i,
    input  logic        dna_start_i,
    input  logic        realign_start_i,
    input  logic        hsk_start_i,
    input  logic [2:0]  clk_control_i,
    output logic        busy_o,
    output logic [56:0] dna_o,
    output logic        dna_valid_o,
    output logic        realign_done_o,
    output logic        realign_timeout_o,
    output logic        bus_sel_o,
    output logic        bus_wr_o,
    output logic        bus_rd_o,
    output logic [1:0]  bus_addr_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i
);

    localparam logic [15:0] GAP_LEN  = 16'(GAP_CYCLES);
    localparam logic [15:0] POLL_LEN = 16'(POLL_INTERVAL);

    state_t      state;
    state_t      next_state;
    logic [5:0]  bit_cnt;
    logic [7:0]  poll_cnt;
    logic        accept_dna;
    logic        accept_ra;
    logic        accept_hsk;
    logic        last_bit;
    logic        poll_exhausted;
    logic        flag_seen;
    logic        wr_req;
    logic        rd_req;
    logic [1:0]  req_addr;
    logic [31:0] req_dat;
    logic [15:0] gap_len;
    logic        gap_done;
    logic        unused_dat_bits;

    // Only bit 0 (DNA) and the realigned flag of the read data are consumed
    assign unused_dat_bits = ^{bus_dat_i[31:6], bus_dat_i[4:1]};

    assign last_bit       = ({1'b0, bit_cnt} + 7'd1) >= 7'(DNA_BITS);
    assign poll_exhausted = ({1'b0, poll_cnt} + 9'd1) >= 9'(POLL_LIMIT);
    assign flag_seen      = bus_dat_i[CTRL_REALIGNED_BIT];
    assign busy_o         = (state != ST_IDLE);

    // State register
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and command acceptance (priority dna > realign > hsk)
    always_comb begin
        next_state = state;
        accept_dna = 1'b0;
        accept_ra  = 1'b0;
        accept_hsk = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dna_start_i) begin
                    accept_dna = 1'b1;
                    next_state = ST_DNA_LOAD;
                end else if (realign_start_i) begin
                    accept_ra  = 1'b1;
                    next_state = ST_RA_WR;
                end else if (hsk_start_i) begin
                    accept_hsk = 1'b1;
                    next_state = ST_HSK_WR;
                end
            end
            ST_DNA_LOAD: next_state = ST_DNA_GAP;
            ST_DNA_GAP:  if (gap_done) next_state = ST_DNA_RD;
            ST_DNA_RD:   next_state = last_bit ? ST_IDLE : ST_DNA_GAP;
            ST_RA_WR:    next_state = ST_RA_GAP;
            ST_RA_GAP:   if (gap_done) next_state = ST_RA_RD;
            ST_RA_RD:    next_state = (flag_seen || poll_exhausted) ? ST_IDLE : ST_RA_GAP;
            ST_HSK_WR:   next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Strobe requests are decoded from the next state so the registered bus
    // strobe is visible exactly while the FSM sits in the matching state.
    always_comb begin
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        req_addr = 2'd0;
        req_dat  = 32'd0;
        gap_len  = GAP_LEN;
        case (next_state)
            ST_DNA_LOAD: begin
                wr_req                = 1'b1;
                req_addr              = ADDR_DNA;
                req_dat[DNA_LOAD_BIT] = 1'b1;
            end
            ST_DNA_RD: begin
                rd_req   = 1'b1;
                req_addr = ADDR_DNA;
            end
            ST_RA_WR: begin
                wr_req   = 1'b1;
                req_addr = ADDR_CONTROL;
                req_dat  = realign_word(clk_control_i);
                gap_len  = POLL_LEN;
            end
            ST_RA_RD: begin
                rd_req   = 1'b1;
                req_addr = ADDR_CONTROL;
                gap_len  = POLL_LEN;
            end
            ST_HSK_WR: begin
                wr_req   = 1'b1;
                req_addr = ADDR_IDENT;
            end
            default: ;
        endcase
    end

    // Counters, DNA shift register and status pulses
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            bit_cnt           <= '0;
            poll_cnt          <= '0;
            dna_o             <= '0;
            dna_valid_o       <= 1'b0;
            realign_done_o    <= 1'b0;
            realign_timeout_o <= 1'b0;
        end else begin
            realign_done_o    <= 1'b0;
            realign_timeout_o <= 1'b0;
            if (accept_dna || accept_ra || accept_hsk) begin
                bit_cnt  <= '0;
                poll_cnt <= '0;
            end
            if (accept_dna) begin
                dna_valid_o <= 1'b0;
            end
            if (state == ST_DNA_RD) begin
                dna_o   <= {dna_o[55:0], bus_dat_i[0]};
                bit_cnt <= bit_cnt + 6'd1;
                if (last_bit) begin
                    dna_valid_o <= 1'b1;
                end
            end
            if (state == ST_RA_RD) begin
                poll_cnt <= poll_cnt + 8'd1;
                if (flag_seen) begin
                    realign_done_o <= 1'b1;
                end else if (poll_exhausted) begin
                    realign_timeout_o <= 1'b1;
                end
            end
        end
    end

    glitc_bus_strobe u_strobe (
        .clk      (user_clk_i),
        .rst_n    (user_rst_n_i),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .req_addr (req_addr),
        .req_dat  (req_dat),
        .gap_len  (gap_len),
        .sel      (bus_sel_o),
        .wr       (bus_wr_o),
        .rd       (bus_rd_o),
        .addr     (bus_addr_o),
        .dat      (bus_dat_o),
        .gap_done (gap_done)
    );

endmodule
